// File: rtl/pwm_kanal.sv
// Single-channel PWM generator: standard duty or triangle "breathing" duty sweep.
// Optional PWM_KANAL_GOLGE_EN latches the config into shadows at period boundaries.
module pwm_kanal #(
   parameter int unsigned VERI_BIT = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [1:0]          kontrol_i,
   input  logic [VERI_BIT-1:0] donem_i,
   input  logic [VERI_BIT-1:0] esik_1_i,
   input  logic [VERI_BIT-1:0] esik_2_i,
   input  logic [VERI_BIT-1:0] adim_i,
   output logic                cikis_o,
   output logic                donem_sonu_o,
   output logic [VERI_BIT-1:0] sayac_o,
   output logic [VERI_BIT-1:0] gorev_o
);

   typedef enum logic [1:0] {ModKapali, ModStandart, ModNefes} mod_e;
   typedef enum logic {YonYukari, YonAsagi} yon_e;

   mod_e                mod;
   logic                en, nefes, ilk_en, nefes_giris;
   logic                p_nz, sarma;
   logic [VERI_BIT-1:0] eff_donem, eff_esik_1, eff_esik_2, eff_adim;
   logic [VERI_BIT:0]   yukari_top, alt_top;

   logic [VERI_BIT-1:0] cnt_q, cnt_d;
   logic [VERI_BIT-1:0] duty_q, duty_d;
   yon_e                yon_q, yon_d;
   logic                cikis_q, cikis_d;
   logic                donem_sonu_q, donem_sonu_d;
   logic                en_q, en_d;
   logic                nefes_q, nefes_d;

   always_comb begin
      case (kontrol_i)
         2'b01:   mod = ModStandart;
         2'b10:   mod = ModNefes;
         default: mod = ModKapali;
      endcase
   end

   assign en          = (mod != ModKapali);
   assign nefes       = (mod == ModNefes);
   assign ilk_en      = en && !en_q;
   assign nefes_giris = nefes && !nefes_q;

`ifdef PWM_KANAL_GOLGE_EN
   logic [VERI_BIT-1:0] donem_g_q, donem_g_d;
   logic [VERI_BIT-1:0] esik_1_g_q, esik_1_g_d;
   logic [VERI_BIT-1:0] esik_2_g_q, esik_2_g_d;
   logic [VERI_BIT-1:0] adim_g_q, adim_g_d;
   logic                golge_yukle;

   // On the first enabled cycle the shadows are stale, so the live inputs pass through.
   assign eff_donem  = ilk_en ? donem_i  : donem_g_q;
   assign eff_esik_1 = ilk_en ? esik_1_i : esik_1_g_q;
   assign eff_esik_2 = ilk_en ? esik_2_i : esik_2_g_q;
   assign eff_adim   = ilk_en ? adim_i   : adim_g_q;

   always_comb begin
      golge_yukle = ilk_en || sarma;
      donem_g_d   = donem_g_q;
      esik_1_g_d  = esik_1_g_q;
      esik_2_g_d  = esik_2_g_q;
      adim_g_d    = adim_g_q;
      if (golge_yukle) begin
         donem_g_d  = donem_i;
         esik_1_g_d = esik_1_i;
         esik_2_g_d = esik_2_i;
         adim_g_d   = adim_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         donem_g_q  <= '0;
         esik_1_g_q <= '0;
         esik_2_g_q <= '0;
         adim_g_q   <= '0;
      end else begin
         donem_g_q  <= donem_g_d;
         esik_1_g_q <= esik_1_g_d;
         esik_2_g_q <= esik_2_g_d;
         adim_g_q   <= adim_g_d;
      end
   end
`else
   assign eff_donem  = donem_i;
   assign eff_esik_1 = esik_1_i;
   assign eff_esik_2 = esik_2_i;
   assign eff_adim   = adim_i;
`endif

   assign p_nz  = (eff_donem != '0);
   // >= rather than == so a period shrunk below the count wraps at once.
   assign sarma = en && p_nz && (cnt_q >= (eff_donem - VERI_BIT'(1)));

   assign yukari_top = {1'b0, duty_q} + {1'b0, eff_adim};
   assign alt_top    = {1'b0, eff_esik_1} + {1'b0, eff_adim};

   always_comb begin
      cnt_d        = cnt_q;
      duty_d       = duty_q;
      yon_d        = yon_q;
      cikis_d      = 1'b0;
      donem_sonu_d = 1'b0;
      en_d         = en;
      nefes_d      = nefes;

      if (!en) begin
         cnt_d  = '0;
         duty_d = eff_esik_1;
         yon_d  = YonYukari;
      end else begin
         if (!p_nz) begin
            cnt_d = '0;
         end else if (sarma) begin
            cnt_d        = '0;
            donem_sonu_d = 1'b1;
         end else begin
            cnt_d = cnt_q + VERI_BIT'(1);
         end

         cikis_d = p_nz && (cnt_q < duty_q);

         if (!nefes) begin
            duty_d = eff_esik_1;
         end else if (nefes_giris) begin
            duty_d = eff_esik_1;
            yon_d  = YonYukari;
         end else if (sarma) begin
            if (eff_esik_1 >= eff_esik_2) begin
               duty_d = eff_esik_1;
               yon_d  = YonYukari;
            end else if (eff_adim == '0) begin
               duty_d = duty_q;
            end else if (yon_q == YonYukari) begin
               if (yukari_top >= {1'b0, eff_esik_2}) begin
                  duty_d = eff_esik_2;
                  yon_d  = YonAsagi;
               end else begin
                  duty_d = yukari_top[VERI_BIT-1:0];
               end
            end else begin
               if ({1'b0, duty_q} <= alt_top) begin
                  duty_d = eff_esik_1;
                  yon_d  = YonYukari;
               end else begin
                  duty_d = duty_q - eff_adim;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q        <= '0;
         duty_q       <= '0;
         yon_q        <= YonYukari;
         cikis_q      <= 1'b0;
         donem_sonu_q <= 1'b0;
         en_q         <= 1'b0;
         nefes_q      <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         duty_q       <= duty_d;
         yon_q        <= yon_d;
         cikis_q      <= cikis_d;
         donem_sonu_q <= donem_sonu_d;
         en_q         <= en_d;
         nefes_q      <= nefes_d;
      end
   end

   assign cikis_o      = cikis_q;
   assign donem_sonu_o = donem_sonu_q;
   assign sayac_o      = cnt_q;
   assign gorev_o      = duty_q;

endmodule

// File: doc/pwm_kanal.md
# pwm_kanal

Single-channel PWM waveform generator that sits directly downstream of the PWM register-file controller. It consumes one channel's configuration (control, period, two thresholds, step) and produces the registered PWM pin output, a period-end pulse, and live counter/duty values for readback. The controller instantiates two of these, one per output pin.

## Interface
Parameters:
- `VERI_BIT`, default 32, width of period/threshold/step/counter datapath.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: synchronous active-high reset.
- `kontrol_i`, input, 2: mode. 00 = off, 01 = standard, 10 = breathing, 11 = off.
- `donem_i`, input, VERI_BIT: period P in clocks.
- `esik_1_i`, input, VERI_BIT: threshold 1. Standard-mode duty; breathing-mode lower bound.
- `esik_2_i`, input, VERI_BIT: threshold 2. Breathing-mode upper bound.
- `adim_i`, input, VERI_BIT: breathing duty step per period.
- `cikis_o`, output, 1: registered PWM output.
- `donem_sonu_o`, output, 1: one-cycle pulse on counter wrap.
- `sayac_o`, output, VERI_BIT: current counter `cnt_r`.
- `gorev_o`, output, VERI_BIT: current duty `duty_r`.

## Operation
- Reset values:
  - `cnt_r` = 0, `duty_r` = 0, direction = up.
  - `cikis_o` = 0, `donem_sonu_o` = 0.
  - Shadow registers = 0.
- Off (00/11):
  - Takes effect immediately; never waits for a period boundary.
  - `cnt_r` ← 0, `duty_r` ← effective esik_1, direction ← up, `cikis_o` ← 0 next cycle, `donem_sonu_o` = 0.
- Counter, when enabled and P ≠ 0:
  - If `cnt_r` ≥ P−1: `cnt_r` ← 0 and `donem_sonu_o` ← 1 in the next cycle ("wrap").
  - Otherwise `cnt_r` ← `cnt_r`+1.
  - The ≥ compare means a period shrunk below the current count wraps on the next cycle.
- P = 0: counter held at 0, `cikis_o` = 0, no wrap pulses.
- Output: `cikis_o` ← (`cnt_r` < `duty_r`) every cycle while enabled.
  - `duty_r` = 0 gives constant low.
  - `duty_r` ≥ P gives constant high.
- Standard mode: `duty_r` ← effective esik_1 every cycle.
- Breathing mode: `duty_r` changes only on wrap, as a triangle sweep. All sums use VERI_BIT+1 bits, with no overflow wrap.
  - Direction up: if `duty_r`+step ≥ esik_2, then `duty_r` ← esik_2 and direction ← down. Otherwise `duty_r` += step.
  - Direction down: if `duty_r` ≤ esik_1+step, then `duty_r` ← esik_1 and direction ← up. Otherwise `duty_r` −= step.
  - step = 0: duty is frozen.
  - esik_1 ≥ esik_2: `duty_r` is held at esik_1.
- Mode change 01↔10 while running: the counter is not reset. On entry to breathing, `duty_r` starts at esik_1 with direction up.

## Timing
- Latency:
  - Off→enabled: first `cnt_r` increment occurs on the first enabled clock.
  - `cikis_o` lags `cnt_r` by exactly 1 cycle.
- `donem_sonu_o` is high in the cycle where `cnt_r` = 0 after a wrap. It is never asserted in the first cycle after leaving off.
- Reset asserted mid-period: all state returns to reset values on that edge. Reset dominates mode.
- Config inputs are treated as static between samples. There is no handshake; the controller's registers drive the inputs directly.

## Configuration
- `PWM_KANAL_GOLGE_EN` defined:
  - donem, esik_1, esik_2 and adim are copied into shadow registers on every wrap, and on the first enabled cycle after off.
  - All arithmetic uses the shadows, giving glitch-free updates at period boundaries.
- Undefined: inputs are used directly and changes take effect the next cycle.
- In both builds, off mode is immediate.

## Test plan
- Standard mode, P=4, esik_1=1: `cikis_o` repeats 1,0,0,0; `donem_sonu_o` pulses every 4 cycles, when `sayac_o`=0.
- Duty extremes, P=5:
  - esik_1=0 → `cikis_o` constant 0.
  - esik_1=7 → constant 1.
  - P=0 → `sayac_o` stuck at 0, no pulses.
- Breathing mode, P=4, esik_1=0, esik_2=3, adim=2: `gorev_o` per period is 0,2,3,1,0,2…
- Period change mid-count with the macro undefined: P=10 reached `sayac_o`=7, then set P=4 → wrap on the next cycle. With `PWM_KANAL_GOLGE_EN` defined, the wrap still occurs at 9.
- Off mid-period at `sayac_o`=2: next cycle `sayac_o`=0 and `cikis_o`=0. Re-enable → counting restarts at 1 with no spurious pulse.
- `rst_i` asserted for 1 cycle while in breathing mode with direction down: all outputs 0; resumes with direction up and duty=esik_1.
